alu_src_stage: RTL and testbench
================================

ALU_SRC_STAGE -- requirements
Module: alu_src_stage

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of all operand ports; legal range 16..64.
REQ-002 Parameter IMM_W, default 16: immediate field width; IMM_W SHALL be no greater than WIDTH-2.
REQ-003 Parameter PC_INC, default 4: constant increment selected for PC+increment.
REQ-004 clk  in  1  single block clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  upstream request carries a valid operand set.
REQ-007 in_ready  out  1  stage can accept a request this cycle.
REQ-008 alusrca  in  1  srcA select: 0 = pc, 1 = a.
REQ-009 alusrcb  in  3  srcB select code (encoding in REQ-016).
REQ-010 pc, a, b  in  WIDTH each  program counter, register A, register B.
REQ-011 imm  in  IMM_W  raw instruction immediate.
REQ-012 out_valid  out  1  srcA/srcB/sel_err hold a valid result.
REQ-013 out_ready  in  1  downstream ALU consumes the result this cycle.
REQ-014 srcA, srcB  out  WIDTH each  registered ALU operands.
REQ-015 sel_err  out  1  result was produced from an illegal alusrcb code; err_cnt  out  8  saturating illegal-code count.

Function
REQ-016 srcB encoding: 000 b; 001 PC_INC; 010 sign-ext imm; 011 sign-ext imm shifted left 2; 100 zero-ext imm; 101 imm placed in bits [IMM_W+15:16] (upper), zeros below; 110/111 illegal -> srcB 0, sel_err 1.
REQ-017 Extension SHALL be to WIDTH bits; shift-by-2 result truncated to WIDTH; upper mode SHALL truncate to WIDTH.
REQ-018 Accept on in_valid && in_ready; operands computed from inputs sampled at acceptance.
REQ-019 Latency: accepted request SHALL appear on outputs with out_valid=1 on the following cycle when the output register is empty or draining.
REQ-020 Transfer on out_valid && out_ready; throughput one result per cycle with out_ready held 1.
REQ-021 Storage: output register plus one skid entry (2 entries total).
REQ-022 in_ready SHALL be a registered signal equal to NOT skid-full; it SHALL NOT combinationally depend on out_ready.
REQ-023 Accept while output valid and not transferring: request SHALL go to skid; in_ready SHALL drop next cycle.
REQ-024 Skid full: in_valid SHALL be ignored; no data lost or overwritten.
REQ-025 Output transfer with skid full: skid SHALL move to output register next cycle, in_ready SHALL rise next cycle.
REQ-026 Simultaneous accept and transfer with skid empty: new result SHALL replace output register, out_valid stays 1.
REQ-027 While out_valid=1 and out_ready=0, srcA, srcB, sel_err SHALL remain stable.
REQ-028 Ordering SHALL be strictly first-in first-out.
REQ-029 err_cnt SHALL increment by one per accepted illegal request and saturate at 255.

Reset
REQ-030 rst_n low SHALL asynchronously clear out_valid, skid-valid, srcA, srcB, sel_err, err_cnt to 0 and set in_ready to 0.
REQ-031 in_ready SHALL rise on the first clock edge after rst_n deasserts; in-flight requests at reset SHALL be discarded.

Structure
REQ-032 Shared package alu_src_pkg SHALL hold the alusrcb code constants and the srcA select constants.
REQ-033 Select/extend logic SHALL be a combinational sub-module alu_src_extend, instantiated once at the input.

Verification
REQ-034 Sel codes: imm=16'h8001, b=32'h1234_5678, out_ready=1, codes 000..101 -> srcB 12345678, 00000004, FFFF8001, FFFE0004, 00008001, 80010000, one cycle after each accept.
REQ-035 Illegal: alusrcb=110 then 111 -> srcB 0, sel_err 1, err_cnt 2; 256 further illegal accepts -> err_cnt 255.
REQ-036 Backpressure: out_ready=0, three back-to-back requests -> first two held (output + skid), in_ready 0 after second, third not accepted; out_ready=1 -> first two emerge in order, in_ready returns 1.
REQ-037 Streaming: out_ready=1, in_valid=1 for 10 cycles with alusrca toggling -> 10 results, one per cycle, srcA alternating pc/a, no gaps.
REQ-038 Reset mid-operation: skid full, rst_n pulsed low off-edge -> out_valid, in_ready, err_cnt 0 immediately; in_ready 1 at first edge after release.
REQ-039 WIDTH=64, IMM_W=16: imm=16'hFFFF code 010 -> srcB all ones; code 101 -> 64'h0000_0000_FFFF_0000.

Source files
------------

// File: rtl/alu_src_pkg.sv
// Shared constants for the ALU source-select stage.
//   - srcA select values (alusrca)
//   - srcB select codes (alusrcb); codes 110 and 111 are illegal
//   - saturation limit of the illegal-code counter
package alu_src_pkg;

   localparam logic SRCA_PC  = 1'b0;
   localparam logic SRCA_REG = 1'b1;

   localparam logic [2:0] SRCB_REG       = 3'b000;
   localparam logic [2:0] SRCB_PC_INC    = 3'b001;
   localparam logic [2:0] SRCB_IMM_SEXT  = 3'b010;
   localparam logic [2:0] SRCB_IMM_SEXT2 = 3'b011;
   localparam logic [2:0] SRCB_IMM_ZEXT  = 3'b100;
   localparam logic [2:0] SRCB_IMM_UPPER = 3'b101;

   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/alu_src_extend.sv
// Combinational operand select / immediate extension.
// Ports:
//   alusrca  - srcA select (pc or a)
//   alusrcb  - srcB select code
//   pc, a, b - program counter, register A, register B
//   imm      - raw instruction immediate
//   src_a    - selected srcA
//   src_b    - selected srcB (0 for an illegal code)
//   sel_err  - alusrcb was an illegal code
module alu_src_extend
   import alu_src_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned IMM_W  = 16,
   parameter int unsigned PC_INC = 4
) (
   input  logic             alusrca,
   input  logic [2:0]       alusrcb,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [IMM_W-1:0] imm,
   output logic [WIDTH-1:0] src_a,
   output logic [WIDTH-1:0] src_b,
   output logic             sel_err
);

   logic [WIDTH-1:0]          imm_sext;
   logic [WIDTH-1:0]          imm_zext;
   logic [WIDTH+IMM_W+15:0]   imm_upper_wide;

   assign imm_sext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
   assign imm_zext = {{(WIDTH-IMM_W){1'b0}}, imm};
   // Built wide so bits landing above WIDTH are simply dropped.
   assign imm_upper_wide = {{(WIDTH+16){1'b0}}, imm} << 16;

   assign src_a = (alusrca == SRCA_REG) ? a : pc;

   always_comb begin
      src_b   = '0;
      sel_err = 1'b0;
      case (alusrcb)
         SRCB_REG:       src_b = b;
         SRCB_PC_INC:    src_b = WIDTH'(PC_INC);
         SRCB_IMM_SEXT:  src_b = imm_sext;
         SRCB_IMM_SEXT2: src_b = imm_sext << 2;
         SRCB_IMM_ZEXT:  src_b = imm_zext;
         SRCB_IMM_UPPER: src_b = imm_upper_wide[WIDTH-1:0];
         default:        sel_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_src_stage.sv
// ALU source stage: selects/extends operands at the input and holds them in
// a two-entry (output register + skid) valid/ready pipeline.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   in_valid, in_ready  - upstream handshake (in_ready is registered)
//   alusrca, alusrcb    - srcA / srcB selects
//   pc, a, b, imm       - operand sources
//   out_valid, out_ready- downstream handshake
//   srcA, srcB, sel_err - registered result
//   err_cnt             - saturating count of accepted illegal codes
module alu_src_stage
   import alu_src_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned IMM_W  = 16,
   parameter int unsigned PC_INC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             alusrca,
   input  logic [2:0]       alusrcb,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [IMM_W-1:0] imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] srcA,
   output logic [WIDTH-1:0] srcB,
   output logic             sel_err,
   output logic [7:0]       err_cnt
);

   logic [WIDTH-1:0] ext_a, ext_b;
   logic             ext_err;

   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic             out_err_q, out_err_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
   logic             skid_err_q, skid_err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic accept;
   logic out_free;

   alu_src_extend #(
      .WIDTH  (WIDTH),
      .IMM_W  (IMM_W),
      .PC_INC (PC_INC)
   ) u_extend (
      .alusrca (alusrca),
      .alusrcb (alusrcb),
      .pc      (pc),
      .a       (a),
      .b       (b),
      .imm     (imm),
      .src_a   (ext_a),
      .src_b   (ext_b),
      .sel_err (ext_err)
   );

   assign accept   = in_valid & in_ready_q;
   // Output register can take new data when empty or being consumed now.
   assign out_free = ~out_valid_q | out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_a_d      = out_a_q;
      out_b_d      = out_b_q;
      out_err_d    = out_err_q;
      skid_valid_d = skid_valid_q;
      skid_a_d     = skid_a_q;
      skid_b_d     = skid_b_q;
      skid_err_d   = skid_err_q;
      err_cnt_d    = err_cnt_q;

      if (out_free) begin
         // in_ready is low whenever skid is full, so skid and accept never
         // compete for the output register.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_a_d      = skid_a_q;
            out_b_d      = skid_b_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_a_d     = ext_a;
            out_b_d     = ext_b;
            out_err_d   = ext_err;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_a_d     = ext_a;
         skid_b_d     = ext_b;
         skid_err_d   = ext_err;
      end

      if (accept && ext_err && (err_cnt_q != ERR_CNT_MAX)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end

      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_a_q      <= '0;
         out_b_q      <= '0;
         out_err_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_a_q     <= '0;
         skid_b_q     <= '0;
         skid_err_q   <= 1'b0;
         err_cnt_q    <= 8'd0;
      end else begin
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_a_q      <= out_a_d;
         out_b_q      <= out_b_d;
         out_err_q    <= out_err_d;
         skid_valid_q <= skid_valid_d;
         skid_a_q     <= skid_a_d;
         skid_b_q     <= skid_b_d;
         skid_err_q   <= skid_err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign srcA      = out_a_q;
   assign srcB      = out_b_q;
   assign sel_err   = out_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_src_stage.sv
// Directed bench for alu_src_stage: select codes, illegal-code counting,
// backpressure through the skid entry, streaming, mid-operation reset and a
// 64-bit instance for extension width.
module tb_alu_src_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, alusrca, out_valid, out_ready, sel_err;
   logic [2:0]  alusrcb;
   logic [31:0] pc, a, b, srcA, srcB;
   logic [15:0] imm;
   logic [7:0]  err_cnt;

   logic        in_valid64, in_ready64, out_valid64, sel_err64;
   logic [2:0]  alusrcb64;
   logic [63:0] srcA64, srcB64;
   logic [15:0] imm64;
   logic [7:0]  err_cnt64;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_src_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alusrca   (alusrca),
      .alusrcb   (alusrcb),
      .pc        (pc),
      .a         (a),
      .b         (b),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .srcA      (srcA),
      .srcB      (srcB),
      .sel_err   (sel_err),
      .err_cnt   (err_cnt)
   );

   alu_src_stage #(
      .WIDTH (64),
      .IMM_W (16)
   ) dut64 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid64),
      .in_ready  (in_ready64),
      .alusrca   (1'b1),
      .alusrcb   (alusrcb64),
      .pc        (64'd0),
      .a         (64'h1111_2222_3333_4444),
      .b         (64'd0),
      .imm       (imm64),
      .out_valid (out_valid64),
      .out_ready (1'b1),
      .srcA      (srcA64),
      .srcB      (srcB64),
      .sel_err   (sel_err64),
      .err_cnt   (err_cnt64)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] sel_exp [6];

   initial begin
      sel_exp[0] = 32'h1234_5678;
      sel_exp[1] = 32'h0000_0004;
      sel_exp[2] = 32'hFFFF_8001;
      sel_exp[3] = 32'hFFFE_0004;
      sel_exp[4] = 32'h0000_8001;
      sel_exp[5] = 32'h8001_0000;

      rst_n = 1'b0; in_valid = 1'b0; alusrca = 1'b0; alusrcb = 3'd0;
      pc = 32'h0000_1000; a = 32'h0000_AAAA; b = 32'h1234_5678; imm = 16'h8001;
      out_ready = 1'b1;
      in_valid64 = 1'b0; alusrcb64 = 3'd0; imm64 = 16'hFFFF;

      // Reset state
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_srcB", srcB, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rel_in_ready_low", in_ready, 0);
      tick();
      check("rel_in_ready_high", in_ready, 1);

      // Select codes, one result per cycle
      in_valid = 1'b1;
      alusrca  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         alusrcb = 3'(i);
         tick();
         check($sformatf("sel%0d_valid", i), out_valid, 1);
         check($sformatf("sel%0d_srcB", i), srcB, sel_exp[i]);
         check($sformatf("sel%0d_err", i), sel_err, 0);
      end
      check("sel_srcA_a", srcA, 32'h0000_AAAA);
      in_valid = 1'b0;
      tick();
      check("sel_drained", out_valid, 0);

      // Illegal codes and saturation
      in_valid = 1'b1;
      alusrcb  = 3'b110;
      tick();
      check("ill6_srcB", srcB, 0);
      check("ill6_err", sel_err, 1);
      check("ill6_cnt", err_cnt, 1);
      alusrcb = 3'b111;
      tick();
      check("ill7_srcB", srcB, 0);
      check("ill7_err", sel_err, 1);
      check("ill7_cnt", err_cnt, 2);
      for (int i = 0; i < 252; i++) tick();
      check("ill_cnt_254", err_cnt, 254);
      for (int i = 0; i < 4; i++) tick();
      check("ill_cnt_sat", err_cnt, 255);
      alusrcb = 3'b000;
      tick();
      check("legal_after_ill_err", sel_err, 0);
      check("legal_cnt_hold", err_cnt, 255);
      in_valid = 1'b0;
      tick();

      // Backpressure: output + skid fill, third request refused
      out_ready = 1'b0;
      in_valid  = 1'b1;
      alusrca   = 1'b0;
      b = 32'd1;
      tick();
      check("bp1_valid", out_valid, 1);
      check("bp1_srcB", srcB, 1);
      check("bp1_in_ready", in_ready, 1);
      b = 32'd2;
      tick();
      check("bp2_srcB_stable", srcB, 1);
      check("bp2_in_ready", in_ready, 0);
      b = 32'd3;
      tick();
      check("bp3_srcB_stable", srcB, 1);
      check("bp3_in_ready", in_ready, 0);
      in_valid = 1'b0;
      tick();
      check("bp_hold_srcB", srcB, 1);
      check("bp_hold_srcA", srcA, 32'h0000_1000);
      out_ready = 1'b1;
      tick();
      check("bp_second_valid", out_valid, 1);
      check("bp_second_srcB", srcB, 2);
      check("bp_in_ready_back", in_ready, 1);
      tick();
      check("bp_third_dropped", out_valid, 0);

      // Streaming 10 cycles, alusrca toggling
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         alusrca = 1'(i % 2);
         pc = 32'h100 + 32'(i);
         a  = 32'h200 + 32'(i);
         b  = 32'h300 + 32'(i);
         tick();
         check($sformatf("st%0d_valid", i), out_valid, 1);
         check($sformatf("st%0d_srcA", i), srcA,
               (i % 2 == 1) ? 32'h200 + 32'(i) : 32'h100 + 32'(i));
         check($sformatf("st%0d_srcB", i), srcB, 32'h300 + 32'(i));
      end
      in_valid = 1'b0;
      tick();
      check("st_end", out_valid, 0);

      // Reset with skid full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      alusrcb   = 3'b110;
      tick();
      tick();
      in_valid = 1'b0;
      check("mr_skid_full", in_ready, 0);
      check("mr_cnt_sat", err_cnt, 255);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_out_valid", out_valid, 0);
      check("mr_in_ready", in_ready, 0);
      check("mr_err_cnt", err_cnt, 0);
      check("mr_sel_err", sel_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      alusrcb = 3'b000;
      check("mr_rel_low", in_ready, 0);
      tick();
      check("mr_rel_high", in_ready, 1);
      check("mr_no_stale", out_valid, 0);

      // 64-bit instance
      in_valid64 = 1'b1;
      alusrcb64  = 3'b010;
      tick();
      check("w64_sext", srcB64, 64'hFFFF_FFFF_FFFF_FFFF);
      alusrcb64 = 3'b011;
      tick();
      check("w64_sext2", srcB64, 64'hFFFF_FFFF_FFFF_FFFC);
      alusrcb64 = 3'b101;
      tick();
      check("w64_upper", srcB64, 64'h0000_0000_FFFF_0000);
      check("w64_srcA", srcA64, 64'h1111_2222_3333_4444);
      in_valid64 = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
